// File: rtl/serial_borrow_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first.
// Operands captured on start; diff/bout/done registered on completion.
module serial_borrow_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sr;
    logic             br;
    logic [CNT_W-1:0] idx;

    logic             ai;
    logic             bi;
    logic             di;
    logic             bo;
    logic [WIDTH-1:0] sr_nxt;

    // Full-subtractor cell for the current bit
    assign ai     = sa[0];
    assign bi     = sb[0];
    assign di     = ai ^ bi ^ br;
    assign bo     = (~ai & bi) | (~(ai ^ bi) & br);
    assign sr_nxt = {di, sr[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sa    <= '0;
            sb    <= '0;
            sr    <= '0;
            br    <= 1'b0;
            idx   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        br    <= bin;
                        sr    <= '0;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    br  <= bo;
                    sr  <= sr_nxt;
                    idx <= idx + 1'b1;
                    if (idx == LAST) begin
                        diff  <= sr_nxt;
                        bout  <= bo;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
